uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Round-robin arbiter that shares the single `uart_transmitter` between several byte sources, such as the cipher echo path, a status/banner generator and an error reporter. It accepts one byte at a time over a valid/ready handshake and holds it stable. It then issues a one-cycle `tx_start` and sequences the transmitter until `tx_done`. Grants are gated by the XON/XOFF `allow_transmit` flag from `flow_control`. The block sits between the requesters and `uart_transmitter` in `uart_echo`-style tops.

## Interface
- `N_REQ`, default 3: number of requesters, range 2..8.
- `DATA_W`, default 8: byte width.
- `TIMEOUT_CYCLES`, default 1_000_000: maximum cycles spent waiting in WAIT_BUSY plus WAIT_DONE before abort; 16-bit minimum counter, sized with `$clog2`.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-low.
- `req_valid`  in  N_REQ  requester i has a byte.
- `req_data`  in  N_REQ*DATA_W  byte of requester i at bits [i*DATA_W +: DATA_W].
- `req_ready`  out  N_REQ  combinational, one-hot or zero; handshake completes when `valid[i] & ready[i]`.
- `allow_transmit`  in  1  XON state from `flow_control`; 0 blocks new grants.
- `tx_busy`  in  1  from transmitter.
- `tx_done`  in  1  one-cycle pulse from transmitter.
- `tx_start`  out  1  one-cycle start pulse, registered.
- `tx_data`  out  DATA_W  holding register, stable from START until return to IDLE.
- `grant_id`  out  $clog2(N_REQ)  index of the byte in flight.
- `active`  out  1  high in every state except IDLE.
- `err_timeout`  out  1  one-cycle pulse on abort.

## Operation
- FSM states: IDLE, START, WAIT_BUSY, WAIT_DONE.
- **IDLE**
  - Eligible when `allow_transmit & !tx_busy & |req_valid`.
  - Winner is the first set `req_valid` bit searched upward from `rr_ptr`, wrapping at N_REQ-1 to 0.
  - `req_ready[winner]`=1 in the same cycle.
  - On the handshake: latch `tx_data`<=data and `grant_id`<=winner, then go to START.
- **START**: `tx_start`=1 for exactly this cycle, then go to WAIT_BUSY; clear the timeout counter.
- **WAIT_BUSY**
  - `tx_busy`=1: go to WAIT_DONE.
  - `tx_done`=1 seen first: treat as completion.
- **WAIT_DONE**: on `tx_done`, set `rr_ptr`<=(`grant_id`+1) mod N_REQ and go to IDLE.
- **Timeout**: the counter increments in WAIT_BUSY and WAIT_DONE. On reaching TIMEOUT_CYCLES-1:
  - pulse `err_timeout`;
  - advance `rr_ptr` as on completion;
  - go to IDLE.
- **Flow control**: `allow_transmit` falling mid-byte does not abort; the byte in flight completes. New grants wait for XON.
- **Round-robin rule**: a requester holding `req_valid` is granted within N_REQ bytes.
- **Arithmetic**: `rr_ptr` wraps modulo N_REQ for non-power-of-two N_REQ; the value N_REQ is never stored.
- Only one byte is in flight at a time; there is no internal FIFO.

## Timing
- Reset values: state=IDLE, `rr_ptr`=0, `tx_start`=0, `tx_data`=0, `grant_id`=0, `active`=0, `err_timeout`=0. `req_ready`=0 while `reset`=0.
- Latency: handshake at cycle T, `tx_start` high at T+1, earliest next `req_ready` at the cycle after `tx_done` is sampled.
- `req_ready` may depend combinationally on `req_valid`. Requesters must hold valid/data until the handshake; `req_valid` must not depend on `req_ready`.
- **Simultaneous events**
  - `tx_done` and the timeout in the same cycle: completion wins, no `err_timeout`.
  - `tx_done` while in START: ignored, because it belongs to an earlier byte.
- **Reset mid-operation**: all registers return to reset values on the next edge; `tx_start` is never asserted for a dropped byte.

## Configuration
- `UART_ARB_PRIORITY_EN`
  - Defined: requester 0 has strict priority. It wins whenever its valid is set in IDLE, and its grant does not move `rr_ptr`. Requesters 1..N_REQ-1 arbitrate round-robin among themselves.
  - Undefined: pure round-robin over all N_REQ requesters, as described above.

## Test plan
- **Single requester**: req 1 offers 8'h41 with `allow_transmit`=1.
  - `req_ready[1]` in the same cycle, `tx_start` at +1 with `tx_data`=8'h41, `grant_id`=1.
  - After `tx_done`, state returns to IDLE with `rr_ptr`=2.
- **Fairness**: all three requesters hold valid continuously for 6 bytes. Grant order is 0,1,2,0,1,2 (undefined macro). With `UART_ARB_PRIORITY_EN` the order is 0,0,0,... until req 0 drops.
- **XOFF**: `allow_transmit`=0 while req 2 is valid gives no `req_ready` and no `tx_start` for 100 cycles. Raising it to 1 gives a grant on the next cycle.
- **XOFF mid-byte**: dropping `allow_transmit` after `tx_start` still lets `tx_done` complete the byte, and no new grant is issued.
- **Timeout**: TIMEOUT_CYCLES=20 with the transmitter model never asserting `tx_busy`/`tx_done`. `err_timeout` pulses 20 cycles after `tx_start`, state returns to IDLE, and `rr_ptr` advances.
- **Reset mid-byte**: `reset`=0 during WAIT_DONE drives all outputs to reset values on the next edge. After release, the first grant goes to req 0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one uart_transmitter between N_REQ byte sources. A requester offers a
// byte on a valid/ready handshake; the granted byte is held in tx_data, a
// one-cycle tx_start is issued, and the block then waits for the transmitter
// to report busy and done before granting the next byte. New grants are only
// issued while allow_transmit (XON) is high and the transmitter is idle.
// A watchdog aborts a byte that never completes and pulses err_timeout.
//
// Parameters:
//   N_REQ          number of requesters (2..8)
//   DATA_W         byte width
//   TIMEOUT_CYCLES cycles allowed in WAIT_BUSY + WAIT_DONE before abort
//
// Ports:
//   clk            clock
//   reset          synchronous reset, active low
//   req_valid      [N_REQ]        requester i has a byte
//   req_data       [N_REQ*DATA_W] byte of requester i at [i*DATA_W +: DATA_W]
//   req_ready      [N_REQ]        combinational grant, one-hot or zero
//   allow_transmit                XON flag; low blocks new grants
//   tx_busy                       transmitter busy
//   tx_done                       transmitter completion pulse
//   tx_start                      registered one-cycle start pulse
//   tx_data        [DATA_W]       byte in flight, held until back in IDLE
//   grant_id       [clog2(N_REQ)] index of the byte in flight
//   active                        high whenever not IDLE
//   err_timeout                   one-cycle pulse on watchdog abort
//
// Build option:
//   UART_ARB_PRIORITY_EN  when defined, requester 0 has strict priority and
//                         its grants never move the round-robin pointer;
//                         requesters 1..N_REQ-1 share round-robin.
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int unsigned N_REQ          = 3,
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*DATA_W-1:0]    req_data,
    output logic [N_REQ-1:0]           req_ready,
    input  logic                       allow_transmit,
    input  logic                       tx_busy,
    input  logic                       tx_done,
    output logic                       tx_start,
    output logic [DATA_W-1:0]          tx_data,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic                       active,
    output logic                       err_timeout
);

    localparam int unsigned ID_W  = $clog2(N_REQ);
    localparam int unsigned SUM_W = ID_W + 1;
    localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES) > 16) ? $clog2(TIMEOUT_CYCLES) : 16;

    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [SUM_W-1:0] N_SUM    = SUM_W'(N_REQ);
    localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    rr_q, rr_d;
    logic               tx_start_q, tx_start_d;
    logic [DATA_W-1:0]  tx_data_q, tx_data_d;
    logic [ID_W-1:0]    grant_q, grant_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               win_found;
    logic [ID_W-1:0]    win_idx;
    logic [SUM_W-1:0]   cand_w;
    logic [ID_W-1:0]    cand;
    logic               handshake;
    logic               waiting;
    logic [CNT_W-1:0]   cnt_inc;
    logic               byte_done;
    logic               timeout_hit;
    logic [ID_W-1:0]    rr_next;

    // -------------------------------------------------------------------------
    // Winner search: first valid requester at or above rr_q, wrapping to 0.
    // The candidate index is formed with one extra bit and folded back by a
    // single subtraction so non-power-of-two N_REQ wraps correctly.
    // -------------------------------------------------------------------------
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand_w    = '0;
        cand      = '0;
`ifdef UART_ARB_PRIORITY_EN
        if (req_valid[0]) begin
            win_found = 1'b1;
            win_idx   = '0;
        end
`endif
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand_w = {1'b0, rr_q} + SUM_W'(k);
            if (cand_w >= N_SUM) begin
                cand_w = cand_w - N_SUM;
            end
            cand = cand_w[ID_W-1:0];
`ifdef UART_ARB_PRIORITY_EN
            if (!win_found && (cand != '0) && req_valid[cand]) begin
`else
            if (!win_found && req_valid[cand]) begin
`endif
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // A grant only exists in IDLE with XON, an idle transmitter and reset
    // released; since req_ready points at a valid requester, asserting it
    // is the handshake.
    assign handshake = reset && (state_q == S_IDLE) && allow_transmit
                       && !tx_busy && win_found;

    // -------------------------------------------------------------------------
    // Watchdog and completion qualifiers
    // -------------------------------------------------------------------------
    assign waiting     = (state_q == S_WAIT_BUSY) || (state_q == S_WAIT_DONE);
    assign cnt_inc     = cnt_q + CNT_W'(1);
    assign byte_done   = waiting && tx_done;
    // Completion in the same cycle as the timeout wins.
    assign timeout_hit = waiting && !tx_done && (cnt_inc == TO_LAST);
    assign rr_next     = (grant_q == ID_LAST) ? '0 : grant_q + ID_W'(1);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            rr_q       <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            grant_q    <= '0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            grant_q    <= grant_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (handshake) begin
                    state_d = S_START;
                end
            end
            // tx_done seen here belongs to an earlier byte and is ignored.
            S_START: begin
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (tx_done || timeout_hit) begin
                    state_d = S_IDLE;
                end else if (tx_busy) begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (tx_done || timeout_hit) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath next values
    // -------------------------------------------------------------------------
    always_comb begin
        tx_start_d = handshake;
        tx_data_d  = tx_data_q;
        grant_d    = grant_q;
        err_d      = timeout_hit;
        rr_d       = rr_q;
        cnt_d      = cnt_q;

        if (handshake) begin
            tx_data_d = req_data[win_idx*DATA_W +: DATA_W];
            grant_d   = win_idx;
        end

        if (state_q == S_START) begin
            cnt_d = '0;
        end else if (waiting) begin
            cnt_d = cnt_inc;
        end

        // Completion and abort both release the pointer past the granted slot.
        if (byte_done || timeout_hit) begin
`ifdef UART_ARB_PRIORITY_EN
            if (grant_q != '0) begin
                rr_d = rr_next;
            end
`else
            rr_d = rr_next;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    always_comb begin
        req_ready = '0;
        if (handshake) begin
            req_ready[win_idx] = 1'b1;
        end
        active = (state_q != S_IDLE);
    end

    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;
    assign grant_id    = grant_q;
    assign err_timeout = err_q;

endmodule
